// File: rtl/led_trail_chaser_if.sv
// Control inputs and display outputs of the LED trail chaser.
// The chaser itself takes the slave side.
interface led_trail_chaser_if #(
    parameter int NSEG  = 7,
    parameter int IDX_W = 3
);
    logic [2:0]       speed;
    logic             dir;
    logic [1:0]       mode;
    logic             tail_en;
    logic             pause;
    logic [NSEG-1:0]  seg_out;
    logic [IDX_W-1:0] head_idx;
    logic             step_pulse;

    modport master (output speed, dir, mode, tail_en, pause,
                    input  seg_out, head_idx, step_pulse);
    modport slave  (input  speed, dir, mode, tail_en, pause,
                    output seg_out, head_idx, step_pulse);
endinterface

// File: rtl/led_trail_chaser.sv
// Multi-channel LED chaser: a full-brightness head walks the channels in one of
// four patterns, leaving an optional PWM-faded trail behind it.
module led_trail_chaser_chan #(
    parameter int FADE_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              is_head_i,
    input  logic              tail_en_i,
    input  logic              fade_tick_i,
    input  logic [FADE_W-1:0] slice_i,
    output logic              lit_o
);
    logic [FADE_W-1:0] bright_q, bright_d;
    logic              lit_q;

    always_comb begin
        bright_d = bright_q;
        if (is_head_i)
            bright_d = '1;
        else if (!tail_en_i)
            bright_d = '0;
        else if (fade_tick_i && bright_q != '0)
            bright_d = bright_q - FADE_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bright_q <= '0;
            lit_q    <= 1'b0;
        end else begin
            bright_q <= bright_d;
            lit_q    <= bright_q > slice_i;
        end
    end

    assign lit_o = lit_q;
endmodule

module led_trail_chaser #(
    parameter int NSEG       = 7,
    parameter int FADE_W     = 4,
    parameter int PWM_W      = 4,
    parameter int STEP_SHIFT = 4,
    parameter int FADE_DIV_W = 2,
    parameter int ACTIVE_LOW = 1,
    parameter int IDX_W      = 3
) (
    input logic               clk,
    input logic               reset,
    led_trail_chaser_if.slave io
);
    localparam int POS_W = (IDX_W > 3) ? IDX_W : 3;
    localparam int CNT_W = STEP_SHIFT + 4;
    localparam logic [1:0] MODE_WRAP   = 2'd0;
    localparam logic [1:0] MODE_BOUNCE = 2'd1;
    localparam logic [1:0] MODE_FIG8   = 2'd2;
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(NSEG - 1);

    // Input copies are deliberately not reset so a held mode does not look
    // like a mode change on reset release.
    logic [2:0] speed_q;
    logic [1:0] mode_q, mode_prev_q;
    logic       dir_q, tail_en_q, pause_q;

    always_ff @(posedge clk) begin
        speed_q     <= io.speed;
        dir_q       <= io.dir;
        mode_q      <= io.mode;
        mode_prev_q <= mode_q;
        tail_en_q   <= io.tail_en;
        pause_q     <= io.pause;
    end

    logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_term;
    logic [POS_W-1:0]      pos_q, pos_d;
    logic                  up_q, up_d;
    logic [PWM_W-1:0]      pwm_q;
    logic [FADE_DIV_W-1:0] fdiv_q;
    logic [IDX_W-1:0]      head, head_idx_q;
    logic                  step_pulse_q, step, chg, fade_tick;
    logic [1:0]            eff_mode;
    logic [2:0]            fig_nxt;

    assign cnt_term  = ((CNT_W'(speed_q) + CNT_W'(1)) << STEP_SHIFT) - CNT_W'(1);
    assign step      = !pause_q && (cnt_q == cnt_term);
    assign chg       = mode_q != mode_prev_q;
    assign fade_tick = (&pwm_q) && (&fdiv_q);
    assign eff_mode  = (mode_q == MODE_FIG8 && NSEG < 7) ? MODE_WRAP : mode_q;
    assign fig_nxt   = dir_q ? pos_q[2:0] + 3'd1 : pos_q[2:0] - 3'd1;

    always_comb begin
        pos_d = pos_q;
        up_d  = up_q;
        cnt_d = cnt_q;
        if (chg) begin
            pos_d = '0;
            up_d  = 1'b1;
            cnt_d = '0;
        end else if (!pause_q) begin
            cnt_d = step ? '0 : cnt_q + CNT_W'(1);
            if (step) begin
                case (eff_mode)
                    MODE_WRAP: begin
                        if (dir_q) pos_d = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
                        else       pos_d = (pos_q == '0) ? POS_LAST : pos_q - POS_W'(1);
                    end
                    MODE_BOUNCE: begin
                        if (up_q) begin
                            if (pos_q == POS_LAST) begin
                                pos_d = POS_LAST - POS_W'(1);
                                up_d  = 1'b0;
                            end else
                                pos_d = pos_q + POS_W'(1);
                        end else begin
                            if (pos_q == '0) begin
                                pos_d = POS_W'(1);
                                up_d  = 1'b1;
                            end else
                                pos_d = pos_q - POS_W'(1);
                        end
                    end
                    MODE_FIG8: pos_d = POS_W'(fig_nxt);
                    default:   pos_d = pos_q;
                endcase
            end
        end
    end

    // Figure-8 walks an 8-step index that visits the middle channel twice.
    always_comb begin
        head = IDX_W'(pos_q);
        if (eff_mode == MODE_FIG8) begin
            case (pos_q[2:0])
                3'd0:    head = IDX_W'(0);
                3'd1:    head = IDX_W'(1);
                3'd2:    head = IDX_W'(6);
                3'd3:    head = IDX_W'(4);
                3'd4:    head = IDX_W'(3);
                3'd5:    head = IDX_W'(2);
                3'd6:    head = IDX_W'(6);
                default: head = IDX_W'(5);
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            pos_q        <= '0;
            up_q         <= 1'b1;
            pwm_q        <= '0;
            fdiv_q       <= '0;
            head_idx_q   <= '0;
            step_pulse_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            pos_q        <= pos_d;
            up_q         <= up_d;
            pwm_q        <= pwm_q + PWM_W'(1);
            if (&pwm_q)
                fdiv_q   <= fdiv_q + FADE_DIV_W'(1);
            head_idx_q   <= head;
            step_pulse_q <= step && !chg;
        end
    end

    logic [NSEG-1:0] lit;

    for (genvar i = 0; i < NSEG; i++) begin : g_chan
        led_trail_chaser_chan #(.FADE_W(FADE_W)) u_chan (
            .clk         (clk),
            .reset       (reset),
            .is_head_i   (head == IDX_W'(i)),
            .tail_en_i   (tail_en_q),
            .fade_tick_i (fade_tick),
            .slice_i     (pwm_q[PWM_W-1 -: FADE_W]),
            .lit_o       (lit[i])
        );
    end

    assign io.seg_out    = (ACTIVE_LOW != 0) ? ~lit : lit;
    assign io.head_idx   = head_idx_q;
    assign io.step_pulse = step_pulse_q;
endmodule

// File: tb/tb_led_trail_chaser.sv
// Bench for led_trail_chaser: directed pattern/fade/pause scenarios plus a
// randomized run against a behavioural model of the chaser.
module tb_led_trail_chaser;
    localparam int NSEG   = 7;
    localparam int IDX_W  = 3;
    localparam int FADE_W = 4;
    localparam int PWM_W  = 4;
    localparam int SS     = 4;
    localparam int FDW    = 2;
    localparam int FULL   = (1 << FADE_W) - 1;
    localparam int PWM_P  = 1 << PWM_W;
    localparam int TICK_P = 1 << (PWM_W + FDW);

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    led_trail_chaser_if #(.NSEG(NSEG), .IDX_W(IDX_W)) bus();

    led_trail_chaser #(
        .NSEG(NSEG), .FADE_W(FADE_W), .PWM_W(PWM_W), .STEP_SHIFT(SS),
        .FADE_DIV_W(FDW), .ACTIVE_LOW(1), .IDX_W(IDX_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .io    (bus)
    );

    int checks = 0;
    int errors = 0;
    int FIG8 [8] = '{0, 1, 6, 4, 3, 2, 6, 5};

    // Model: t counts cycles since reset release, so PWM phase and fade ticks
    // follow directly from it.
    int t;
    int r_speed, r_dir, r_mode, r_prev, r_tail, r_pause;
    int m_cnt, m_pos, m_up, m_hidx, m_sp;
    int m_b [NSEG];
    bit m_lit [NSEG];
    int seq_q[$];
    int pulse_q[$];

    function automatic int head_of(int mode, int pos);
        if (mode == 2 && NSEG >= 7) return FIG8[pos % 8];
        return pos;
    endfunction

    task automatic advance();
        if (r_mode == 2 && NSEG >= 7)
            m_pos = (m_pos + (r_dir != 0 ? 1 : 7)) % 8;
        else if (r_mode == 1) begin
            if (m_up != 0) begin
                if (m_pos == NSEG - 1) begin m_pos = NSEG - 2; m_up = 0; end
                else m_pos++;
            end else begin
                if (m_pos == 0) begin m_pos = 1; m_up = 1; end
                else m_pos--;
            end
        end else if (r_mode != 3)
            m_pos = (m_pos + (r_dir != 0 ? 1 : NSEG - 1)) % NSEG;
    endtask

    task automatic model_edge();
        int head, slice;
        bit tick, stp, chg;
        if (reset) begin
            t = 0; m_cnt = 0; m_pos = 0; m_up = 1; m_hidx = 0; m_sp = 0;
            foreach (m_b[c]) begin m_b[c] = 0; m_lit[c] = 1'b0; end
        end else begin
            head  = head_of(r_mode, m_pos);
            slice = (t % PWM_P) >> (PWM_W - FADE_W);
            tick  = (t % TICK_P) == TICK_P - 1;
            foreach (m_b[c]) begin
                m_lit[c] = m_b[c] > slice;
                if (c == head) m_b[c] = FULL;
                else if (r_tail == 0) m_b[c] = 0;
                else if (tick && m_b[c] > 0) m_b[c]--;
            end
            m_hidx = head;
            stp  = (r_pause == 0) && (m_cnt == ((r_speed + 1) << SS) - 1);
            chg  = r_mode != r_prev;
            m_sp = (stp && !chg) ? 1 : 0;
            if (chg) begin
                m_pos = 0; m_up = 1; m_cnt = 0;
            end else if (r_pause == 0) begin
                if (stp) begin m_cnt = 0; advance(); end
                else m_cnt++;
            end
            t++;
        end
        r_prev  = r_mode;
        r_speed = int'(bus.speed);
        r_dir   = int'(bus.dir);
        r_mode  = int'(bus.mode);
        r_tail  = int'(bus.tail_en);
        r_pause = int'(bus.pause);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic restart();
        reset = 1'b1;
        repeat (3) cyc();
        reset = 1'b0;
    endtask

    task automatic set_in(input int speed, input int mode, input int dir, input int tail);
        bus.speed   = 3'(speed);
        bus.mode    = 2'(mode);
        bus.dir     = 1'(dir);
        bus.tail_en = 1'(tail);
        bus.pause   = 1'b0;
    endtask

    task automatic capture(input int ncyc);
        int last;
        last = -1;
        seq_q = {};
        pulse_q = {};
        for (int n = 1; n <= ncyc; n++) begin
            cyc();
            if (int'(bus.head_idx) != last) begin
                last = int'(bus.head_idx);
                seq_q.push_back(last);
            end
            if (bus.step_pulse === 1'b1) pulse_q.push_back(n);
        end
    endtask

    task automatic test_reset();
        set_in(0, 0, 1, 1);
        restart();
        checks += 3;
        if (bus.seg_out !== 7'h7f) begin errors++; $display("FAIL reset_seg got %b want %b", bus.seg_out, 7'h7f); end
        if (bus.head_idx !== 3'd0) begin errors++; $display("FAIL reset_head got %0d want 0", bus.head_idx); end
        if (bus.step_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got %b want 0", bus.step_pulse); end
        repeat (47) cyc();
        reset = 1'b1;
        cyc();
        checks += 3;
        if (bus.seg_out !== 7'h7f) begin errors++; $display("FAIL midreset_seg got %b want %b", bus.seg_out, 7'h7f); end
        if (bus.head_idx !== 3'd0) begin errors++; $display("FAIL midreset_head got %0d want 0", bus.head_idx); end
        if (bus.step_pulse !== 1'b0) begin errors++; $display("FAIL midreset_pulse got %b want 0", bus.step_pulse); end
        reset = 1'b0;
    endtask

    task automatic test_linear();
        int exp_seq [8] = '{0, 1, 2, 3, 4, 5, 6, 0};
        int got;
        set_in(0, 0, 1, 1);
        restart();
        capture(130);
        for (int i = 0; i < 8; i++) begin
            got = (i < seq_q.size()) ? seq_q[i] : -1;
            checks++;
            if (got != exp_seq[i]) begin errors++; $display("FAIL linear_head[%0d] got %0d want %0d", i, got, exp_seq[i]); end
            got = (i < pulse_q.size()) ? pulse_q[i] : -1;
            checks++;
            if (got != 16 * (i + 1)) begin errors++; $display("FAIL linear_pulse[%0d] got cycle %0d want %0d", i, got, 16 * (i + 1)); end
        end
        checks++;
        if (pulse_q.size() != 8) begin errors++; $display("FAIL linear_npulse got %0d want 8", pulse_q.size()); end
    endtask

    task automatic test_bounce();
        int exp_seq [14] = '{0, 1, 2, 3, 4, 5, 6, 5, 4, 3, 2, 1, 0, 1};
        int got;
        set_in(0, 1, 0, 1);
        restart();
        capture(210);
        checks++;
        if (seq_q.size() != 14) begin errors++; $display("FAIL bounce_len got %0d want 14", seq_q.size()); end
        for (int i = 0; i < 14; i++) begin
            got = (i < seq_q.size()) ? seq_q[i] : -1;
            checks++;
            if (got != exp_seq[i]) begin errors++; $display("FAIL bounce_head[%0d] got %0d want %0d", i, got, exp_seq[i]); end
        end
    endtask

    task automatic test_fig8();
        int exp_seq [9] = '{0, 5, 6, 2, 3, 4, 6, 1, 0};
        int got;
        set_in(0, 2, 0, 1);
        restart();
        capture(130);
        checks++;
        if (seq_q.size() != 9) begin errors++; $display("FAIL fig8_len got %0d want 9", seq_q.size()); end
        for (int i = 0; i < 9; i++) begin
            got = (i < seq_q.size()) ? seq_q[i] : -1;
            checks++;
            if (got != exp_seq[i]) begin errors++; $display("FAIL fig8_head[%0d] got %0d want %0d", i, got, exp_seq[i]); end
        end
    endtask

    // Channel 0 brightness is read back as its lit count per PWM period.
    task automatic test_fade_pause();
        int lit_cnt, exp_b, bad_sp, bad_hd, first;
        set_in(0, 0, 1, 1);
        restart();
        repeat (16) cyc();
        bus.pause = 1'b1;
        lit_cnt = 0; bad_sp = 0; bad_hd = 0;
        for (int n = 17; n <= 16 * 64; n++) begin
            cyc();
            if (bus.seg_out[0] === 1'b0) lit_cnt++;
            if (bus.step_pulse !== 1'b0) bad_sp++;
            if (bus.head_idx !== 3'd1) bad_hd++;
            if (n % 16 == 0) begin
                exp_b = FULL - ((n / 16 - 1) * PWM_P) / TICK_P;
                if (exp_b < 0) exp_b = 0;
                checks++;
                if (lit_cnt != exp_b) begin errors++; $display("FAIL fade_win%0d got %0d want %0d", n / 16 - 1, lit_cnt, exp_b); end
                lit_cnt = 0;
            end
        end
        checks += 2;
        if (bad_sp != 0) begin errors++; $display("FAIL pause_pulse got %0d pulses want 0", bad_sp); end
        if (bad_hd != 0) begin errors++; $display("FAIL pause_head got %0d moves want 0", bad_hd); end
        bus.pause = 1'b0;
        first = -1;
        for (int k = 1; k <= 17; k++) begin
            cyc();
            if (bus.step_pulse === 1'b1 && first < 0) first = k;
        end
        checks += 2;
        if (first != 16) begin errors++; $display("FAIL resume_pulse got %0d want 16", first); end
        if (bus.head_idx !== 3'd2) begin errors++; $display("FAIL resume_head got %0d want 2", bus.head_idx); end
    endtask

    task automatic test_tail_off();
        int lit2, lit3, bad;
        set_in(0, 0, 1, 1);
        restart();
        repeat (44) cyc();
        lit2 = 0;
        repeat (16) begin
            cyc();
            if (bus.seg_out[2] === 1'b0) lit2++;
        end
        checks++;
        if (lit2 != FULL) begin errors++; $display("FAIL trail_ch2 got %0d want %0d", lit2, FULL); end
        bus.pause = 1'b1;
        bus.tail_en = 1'b0;
        repeat (2) cyc();
        lit3 = 0; bad = 0;
        repeat (16) begin
            cyc();
            if (bus.seg_out[3] === 1'b0) lit3++;
            if ((bus.seg_out | 7'b0001000) !== 7'h7f) bad++;
        end
        checks += 2;
        if (lit3 != FULL) begin errors++; $display("FAIL headonly_ch3 got %0d want %0d", lit3, FULL); end
        if (bad != 0) begin errors++; $display("FAIL headonly_others got %0d lit cycles want 0", bad); end
    endtask

    task automatic test_random();
        logic [NSEG-1:0] exp_seg;
        for (int r = 0; r < 6; r++) begin
            set_in(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
            restart();
            for (int n = 0; n < 600; n++) begin
                if ($urandom_range(0, 49) == 0) bus.dir = ~bus.dir;
                if ($urandom_range(0, 59) == 0) bus.tail_en = ~bus.tail_en;
                if ($urandom_range(0, 39) == 0) bus.pause = ~bus.pause;
                if ($urandom_range(0, 149) == 0) bus.mode = 2'($urandom_range(0, 3));
                reset = ($urandom_range(0, 299) == 0);
                cyc();
                for (int c = 0; c < NSEG; c++) exp_seg[c] = ~m_lit[c];
                checks += 3;
                if (bus.seg_out !== exp_seg) begin errors++; $display("FAIL rand_seg r%0d n%0d got %b want %b", r, n, bus.seg_out, exp_seg); end
                if (bus.head_idx !== IDX_W'(m_hidx)) begin errors++; $display("FAIL rand_head r%0d n%0d got %0d want %0d", r, n, bus.head_idx, m_hidx); end
                if (bus.step_pulse !== 1'(m_sp)) begin errors++; $display("FAIL rand_pulse r%0d n%0d got %b want %0d", r, n, bus.step_pulse, m_sp); end
            end
            reset = 1'b0;
        end
    endtask

    initial begin
        set_in(0, 0, 1, 1);
        test_reset();
        test_linear();
        test_bounce();
        test_fig8();
        test_fade_pause();
        test_tail_off();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/led_trail_chaser.md
LED_TRAIL_CHASER -- requirements
Module: led_trail_chaser

Interface
REQ-001 SHALL provide parameter NSEG, default 7, number of LED channels (>=2).
REQ-002 SHALL provide parameter FADE_W, default 4, per-channel brightness width.
REQ-003 SHALL provide parameter PWM_W, default 4, free-running PWM counter width (>=FADE_W).
REQ-004 SHALL provide parameter STEP_SHIFT, default 4, giving step period = (speed+1) << STEP_SHIFT cycles.
REQ-005 SHALL provide parameter FADE_DIV_W, default 2, giving fade tick every 2^(PWM_W+FADE_DIV_W) cycles.
REQ-006 SHALL provide parameter ACTIVE_LOW, default 1, output polarity (1 = common anode).
REQ-007 SHALL provide parameter IDX_W, default 3, width of head_idx (2^IDX_W >= NSEG).
REQ-008 clk  input  1  rising-edge clock.
REQ-009 reset  input  1  synchronous, active-high reset.
REQ-010 speed  input  3  step-rate select, 0 fastest.
REQ-011 dir  input  1  1 = ascending, 0 = descending (modes 0 and 2).
REQ-012 mode  input  2  0 linear wrap, 1 bounce, 2 figure-8, 3 hold.
REQ-013 tail_en  input  1  1 = fading trail, 0 = head only.
REQ-014 pause  input  1  1 = freeze stepping; fading continues.
REQ-015 seg_out  output  NSEG  PWM-driven channel drive, polarity per ACTIVE_LOW.
REQ-016 head_idx  output  IDX_W  channel currently at full brightness.
REQ-017 step_pulse  output  1  one-cycle pulse on each position advance.

Function
REQ-018 speed, dir, mode, tail_en, pause SHALL be registered once; all logic SHALL use the registered copies, adding 1 cycle of input latency.
REQ-019 Step counter SHALL count 0..((speed+1)<<STEP_SHIFT)-1; at the terminal value it SHALL clear and assert step_pulse for exactly that cycle; while pause=1 it SHALL hold and step_pulse SHALL stay 0.
REQ-020 Mode 0: on step, pos SHALL become pos+1 (dir=1) or pos-1 (dir=0), wrapping between NSEG-1 and 0; head channel = pos.
REQ-021 Mode 1: pos SHALL ping-pong 0..NSEG-1 via internal up flag; at NSEG-1 moving up next pos SHALL be NSEG-2 with flag cleared; at 0 moving down next pos SHALL be 1 with flag set; dir ignored.
REQ-022 Mode 2: pos SHALL be a 3-bit index stepped per dir with wrap 7<->0; head channel SHALL map as index 0..7 -> 0,1,6,4,3,2,6,5; if NSEG<7 mode 2 SHALL behave as mode 0.
REQ-023 Mode 3: pos SHALL hold; step_pulse SHALL still pulse.
REQ-024 When registered mode changes, the next cycle SHALL set pos=0, up flag=1, step counter=0; brightness SHALL be unaffected.
REQ-025 head_idx SHALL equal the head channel, registered, same cycle brightness is loaded.
REQ-026 PWM counter SHALL free-run modulo 2^PWM_W; slice = its top FADE_W bits.
REQ-027 Fade tick SHALL be asserted when PWM counter and fade divider are both all-ones; the divider SHALL increment on each PWM wrap.
REQ-028 Per cycle, channel brightness priority: head channel = all-ones; else tail_en=0 -> 0; else fade tick -> saturating decrement by 1 (0 stays 0); else hold.
REQ-029 Lit(i) SHALL be registered as brightness(i) > slice; seg_out(i) = Lit(i) XOR ACTIVE_LOW; one cycle after brightness.
REQ-030 All-ones brightness SHALL yield duty (2^FADE_W-1)/2^FADE_W; zero SHALL yield never lit.

Reset
REQ-031 While reset=1: step counter, PWM counter, fade divider, pos, all brightness = 0; up flag = 1; step_pulse = 0; head_idx = 0; Lit all 0, so seg_out = all ones when ACTIVE_LOW=1, all zeros otherwise.
REQ-032 Reset mid-step SHALL abandon the step with no step_pulse; first cycle after release channel 0 SHALL load full brightness.
REQ-033 Reset SHALL take priority over every other event, including pause and mode change.

Verification
REQ-034 Defaults, mode 0, dir=1, speed=0, pause=0: step_pulse every 16 cycles; head_idx 0,1,..,6,0 wrapping.
REQ-035 Mode 1, speed=0: head_idx sequence 0..6,5,4..0,1; no repeated index at either end.
REQ-036 Mode 2, dir=0 from reset: head_idx 0,5,6,2,3,4,6,1,0.
REQ-037 tail_en=1, head leaves channel 0: channel 0 brightness 15->14->... one per 64 cycles to 0, then holds; tail_en=0: non-head channels 0 within 2 cycles.
REQ-038 pause=1 for 100 cycles: no step_pulse, head_idx constant, trail still decrements; pause=0: stepping resumes from held count.
REQ-039 Reset asserted mid-operation with ACTIVE_LOW=1: next cycle seg_out=7'b1111111, head_idx=0, step_pulse=0.
